cic_rate_ctrl: RTL



---
 rtl/cic_rate_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cic_rate_ctrl.sv
// -----------------------------------------------------------------------------
// cic_rate_ctrl
//
// Purpose: sits between an upstream sample source, a cic_decimator instance and
// the downstream consumer, and owns the decimator's rate input and synchronous
// reset. A rate change runs in a fixed order: block input, drain the pending
// output, reset the filter while loading the new rate, discard the N settling
// outputs, then resume full streaming. The same flush/settle sequence runs
// after power-on reset.
//
// States: FLUSH (cic_rst high for two cycles) -> SETTLE (discard N outputs)
//         -> RUN (passthrough, accepts cfg) -> DRAIN (finish pending output)
//         -> FLUSH.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cfg_rate/cfg_valid/cfg_ready    rate change request (accepted only in RUN)
//   s_tdata/s_tvalid/s_tready       upstream sample stream
//   cic_input_*                     to/from decimator input
//   cic_output_*                    to/from decimator output
//   m_tdata/m_tvalid/m_tready       downstream sample stream
//   cic_rst                         registered active-high sync reset to decimator
//   cic_rate                        registered rate to decimator
//   busy                            high in every state except RUN
//
// Optional feature (macro CIC_DROP_CNT_EN):
//   drop_count[15:0]                saturating count of discarded settle outputs
// -----------------------------------------------------------------------------
module cic_rate_ctrl #(
  parameter int WIDTH        = 16,
  parameter int RMAX         = 4,
  parameter int M            = 1,
  parameter int N            = 2,
  parameter int DEFAULT_RATE = 4,
  parameter int RW           = $clog2(RMAX + 1),
  parameter int REG_WIDTH    = WIDTH + $clog2((RMAX * M) ** N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RW-1:0]        cfg_rate,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WIDTH-1:0]     s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [WIDTH-1:0]     cic_input_tdata,
  output logic                 cic_input_tvalid,
  input  logic                 cic_input_tready,
  input  logic [REG_WIDTH-1:0] cic_output_tdata,
  input  logic                 cic_output_tvalid,
  output logic                 cic_output_tready,
  output logic [REG_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 cic_rst,
  output logic [RW-1:0]        cic_rate,
  output logic                 busy
`ifdef CIC_DROP_CNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  localparam int SCW = $clog2(N + 1);

  typedef enum logic [1:0] {
    FLUSH,
    SETTLE,
    RUN,
    DRAIN
  } state_t;

  state_t         state, state_next;
  logic           flush_cnt;    // one bit: cic_rst spans exactly two cycles
  logic [SCW-1:0] settle_cnt;
  logic [RW-1:0]  rate_q;       // requested rate, held until the next flush
  logic           cfg_fire;
  logic           out_fire;
  logic           settle_done;

  // Out-of-range requests are pulled into 1..RMAX so the decimator never
  // sees an illegal rate.
  function automatic logic [RW-1:0] clamp_rate(input logic [RW-1:0] r);
    if (r == '0)          return RW'(1);
    if (int'(r) > RMAX)   return RW'(RMAX);
    return r;
  endfunction

  assign cfg_fire    = cfg_valid && cfg_ready;
  assign out_fire    = cic_output_tvalid && cic_output_tready;
  assign settle_done = (settle_cnt == SCW'(N - 1));

  // Data never needs muxing; only the handshakes are gated by state.
  assign cic_input_tdata = s_tdata;
  assign m_tdata         = cic_output_tdata;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) state <= FLUSH;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next        = state;
    cfg_ready         = 1'b0;
    s_tready          = 1'b0;
    cic_input_tvalid  = 1'b0;
    cic_output_tready = 1'b0;
    m_tvalid          = 1'b0;
    busy              = 1'b1;

    unique case (state)
      FLUSH: begin
        if (flush_cnt) state_next = SETTLE;
      end

      SETTLE: begin
        // Filter is refilling: feed it, swallow its output.
        cic_input_tvalid  = s_tvalid;
        s_tready          = cic_input_tready;
        cic_output_tready = 1'b1;
        if (out_fire && settle_done) state_next = RUN;
      end

      RUN: begin
        cic_input_tvalid  = s_tvalid;
        s_tready          = cic_input_tready;
        m_tvalid          = cic_output_tvalid;
        cic_output_tready = m_tready;
        cfg_ready         = 1'b1;
        busy              = 1'b0;
        if (cfg_fire) state_next = DRAIN;
      end

      DRAIN: begin
        // Input stays blocked; a completed output may still be delivered.
        m_tvalid          = cic_output_tvalid;
        cic_output_tready = m_tready;
        if (!cic_output_tvalid || m_tready) state_next = FLUSH;
      end

      default: state_next = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cic_rst    <= 1'b1;
      cic_rate   <= RW'(DEFAULT_RATE);
      rate_q     <= RW'(DEFAULT_RATE);
      flush_cnt  <= 1'b0;
      settle_cnt <= '0;
    end else begin
      // Registered so the decimator reset is glitch-free and aligned with FLUSH.
      cic_rst   <= (state_next == FLUSH);
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;

      if (cfg_fire) rate_q <= clamp_rate(cfg_rate);

      // New rate lands on the same edge that raises cic_rst.
      if (state == DRAIN && state_next == FLUSH) cic_rate <= rate_q;

      if (state == SETTLE && out_fire)
        settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
    end
  end

`ifdef CIC_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_count <= '0;
    else if (state == SETTLE && out_fire && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule
